// File: rtl/rs_pipeline_sink_fifo.sv
// Sink FIFO at the tail of a relay-station pipeline. It keeps GRACE_PERIOD slots spare for words already in flight.
// Optional sticky overflow detection is enabled with RS_PIPELINE_SINK_OVERFLOW_CHECK_EN.
module rs_pipeline_sink_fifo #(
  parameter int DATA_WIDTH     = 32,
  parameter int DEPTH          = 16,
  parameter int ADDR_WIDTH     = 4,
  parameter int GRACE_PERIOD   = 6,
  parameter int PIPELINE_LEVEL = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] if_din,
  input  logic                  if_write,
  output logic                  if_full_n,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n,
  input  logic                  if_read,
  output logic                  overflow
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] THRESH_C = (ADDR_WIDTH+1)'(DEPTH - GRACE_PERIOD);

  generate
    if (GRACE_PERIOD < 2 * PIPELINE_LEVEL) begin : g_bad_grace
      $error("GRACE_PERIOD must be at least 2*PIPELINE_LEVEL");
    end
    if ((DEPTH < GRACE_PERIOD + 2) || (DEPTH != (1 << ADDR_WIDTH))) begin : g_bad_depth
      $error("DEPTH must equal 2**ADDR_WIDTH and be at least GRACE_PERIOD+2");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [ADDR_WIDTH:0]   count_reg, count_next;
  logic                  empty_n_reg, full_n_reg;
  logic                  rd_accept, wr_accept;

  assign rd_accept = if_read & empty_n_reg;
  // A read on the same cycle frees the slot, so a write into a full FIFO is still taken.
  assign wr_accept = if_write & ((count_reg != DEPTH_C) | rd_accept);

  always_comb begin
    count_next = count_reg;
    case ({wr_accept, rd_accept})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset && wr_accept) begin
      mem[wr_ptr_reg] <= if_din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      empty_n_reg <= 1'b0;
      full_n_reg  <= 1'b1;
    end else begin
      if (wr_accept) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rd_accept) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg   <= count_next;
      empty_n_reg <= (count_next != '0);
      full_n_reg  <= (count_next < THRESH_C);
    end
  end

  assign if_dout    = mem[rd_ptr_reg];
  assign if_empty_n = empty_n_reg;
  assign if_full_n  = full_n_reg;

`ifdef RS_PIPELINE_SINK_OVERFLOW_CHECK_EN
  logic overflow_reg;
  logic drop;

  assign drop = if_write & ~wr_accept;

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_reg <= 1'b0;
    end else if (drop) begin
      overflow_reg <= 1'b1;
      $error("rs_pipeline_sink_fifo: write dropped while full at time %0t", $time);
    end
  end

  assign overflow = overflow_reg;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_rs_pipeline_sink_fifo.sv
// Randomized bench for rs_pipeline_sink_fifo, checked against a queue-based reference model.
module tb_rs_pipeline_sink_fifo;

  localparam int DEPTH  = 16;
  localparam int THRESH = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] if_din;
  logic        if_write;
  logic        if_full_n;
  logic [31:0] if_dout;
  logic        if_empty_n;
  logic        if_read;
  logic        overflow;

  rs_pipeline_sink_fifo dut (
    .clk       (clk),
    .reset     (reset),
    .if_din    (if_din),
    .if_write  (if_write),
    .if_full_n (if_full_n),
    .if_dout   (if_dout),
    .if_empty_n(if_empty_n),
    .if_read   (if_read),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int          tests  = 0;
  int          failed = 0;
  logic [31:0] q[$];
  logic        ovf_exp;
  logic [31:0] last_pop;
  logic        seen_aa;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_empty_n"}, 64'(if_empty_n), 64'(q.size() != 0));
    check({tag, "_full_n"},  64'(if_full_n),  64'(q.size() < THRESH));
    check({tag, "_count"},   64'(dut.count_reg), 64'(q.size()));
    check({tag, "_ovf"},     64'(overflow),   64'(ovf_exp));
    if (q.size() != 0) check({tag, "_dout"}, 64'(if_dout), 64'(q[0]));
  endtask

  // One clock cycle: present inputs, let the edge happen, update the model, compare.
  task automatic step(input logic w, input logic [31:0] d, input logic r, input string tag);
    logic [31:0] dout_pre;
    logic        rd_acc, wr_acc;
    int          size_before;
    if_write = w; if_din = d; if_read = r;
    dout_pre = if_dout;
    @(posedge clk);
    size_before = q.size();
    rd_acc = r && (size_before != 0);
    wr_acc = w && ((size_before < DEPTH) || rd_acc);
    if (rd_acc) begin
      void'(q.pop_front());
      last_pop = dout_pre;
      if (dout_pre == 32'hAA) seen_aa = 1'b1;
    end
    if (wr_acc) q.push_back(d);
`ifdef RS_PIPELINE_SINK_OVERFLOW_CHECK_EN
    if (w && !wr_acc) ovf_exp = 1'b1;
`endif
    #1;
    if_write = 1'b0; if_read = 1'b0;
    check_state(tag);
    $display("[TB] %s wr=%0b din=%0h rd=%0b size=%0d full_n=%0b", tag, w, d, r, q.size(), if_full_n);
  endtask

  task automatic do_reset(input logic w);
    reset = 1'b1; if_write = w; if_din = 32'hDEAD_BEEF; if_read = 1'b0;
    @(posedge clk);
    q.delete();
    ovf_exp = 1'b0;
    #1;
    reset = 1'b0; if_write = 1'b0;
    check_state("reset");
    $display("[TB] reset wr=%0b", w);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 32'h0, 1'b1, tag);
  endtask

  initial begin
    logic [5:0] hist;
    int         pushed;
    int         cycles;
    reset = 1'b1; if_write = 1'b0; if_read = 1'b0; if_din = '0;
    ovf_exp = 1'b0; last_pop = '0; seen_aa = 1'b0;
    repeat (2) @(posedge clk);
    do_reset(1'b0);

    // Three writes, no reads
    step(1'b1, 32'h11, 1'b0, "w3");
    step(1'b1, 32'h22, 1'b0, "w3");
    step(1'b1, 32'h33, 1'b0, "w3");

    // Fill to 16 with the in-flight tail, then drain in order
    do_reset(1'b0);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 32'(i), 1'b0, "fill");
    drain("drain");
    check("drain_last", 64'(last_pop), 64'(DEPTH - 1));

    // Write while full is dropped
    for (int i = 0; i < DEPTH; i++) step(1'b1, 32'(i + 100), 1'b0, "fill2");
    seen_aa = 1'b0;
    step(1'b1, 32'hAA, 1'b0, "drop");
    step(1'b0, 32'h0, 1'b0, "drop_hold");
    drain("drain2");
    check("aa_absent", 64'(seen_aa), 64'(0));

    // Simultaneous read and write while full
    do_reset(1'b0);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 32'(i + 200), 1'b0, "fill3");
    step(1'b1, 32'hBB, 1'b1, "rw_full");
    drain("drain3");
    check("bb_last", 64'(last_pop), 64'hBB);

    // Random traffic: writer honours full_n seen 2*PIPELINE_LEVEL cycles earlier
    do_reset(1'b0);
    hist = '1; pushed = 0; cycles = 0;
    while ((pushed < 40 || q.size() != 0) && cycles < 2000) begin
      logic w, r;
      w = (pushed < 40) && hist[5] && ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 1) == 1);
      step(w, $urandom, r, "rand");
      if (w) pushed++;
      hist = {hist[4:0], if_full_n};
      cycles++;
    end
    check("rand_pushed", 64'(pushed), 64'(40));
    check("rand_done",   64'(q.size()), 64'(0));

    // Reset mid-operation with a write pending
    for (int i = 0; i < 7; i++) step(1'b1, 32'(i + 300), 1'b0, "pre_rst");
    do_reset(1'b1);
    step(1'b1, 32'h5A, 1'b0, "post_rst");
    step(1'b0, 32'h0, 1'b1, "post_rst_rd");
    check("post_rst_first", 64'(last_pop), 64'h5A);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
